// File: rtl/noc_vc_alloc_bridge.sv
// Steers packets from one flit input onto NUM_VC virtual channels, locking a whole packet to one round-robin VC.
// Optional orphan-flit dropping and counting: define NOC_VC_ALLOC_BRIDGE_ERRCHK_EN.
module noc_vc_alloc_bridge #(
  parameter int DATA_W = 64,
  parameter int NUM_VC = 4
) (
  input  logic              noc_clk,
  input  logic              noc_rst,
  input  logic              Noc_receive_valid,
  output logic              Noc_receive_ready,
  input  logic [DATA_W-1:0] Noc_receive_flit,
  input  logic              Noc_receive_is_header,
  input  logic              Noc_receive_is_tail,
  output logic [NUM_VC-1:0] Noc_sender_valid,
  input  logic [NUM_VC-1:0] Noc_sender_ready,
  input  logic [NUM_VC-1:0] Noc_sender_VCready,
  output logic [DATA_W-1:0] Noc_sender_flit,
  output logic              Noc_sender_is_header,
  output logic              Noc_sender_is_tail
`ifdef NOC_VC_ALLOC_BRIDGE_ERRCHK_EN
  ,
  output logic              err_orphan,
  output logic [7:0]        err_cnt
`endif
);

  // state  | meaning
  // S_IDLE | waiting for a header at the FIFO head and a VCready channel to allocate
  // S_PKT  | VC locked; every popped flit goes to r_lock_vc until the tail leaves

  localparam int VW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

  typedef enum logic {S_IDLE, S_PKT} state_t;

  typedef struct packed {
    logic              hdr;
    logic              tail;
    logic [DATA_W-1:0] flit;
  } entry_t;

  entry_t            r_mem [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  state_t            r_state;
  logic [NUM_VC-1:0] r_lock_vc;
  logic [VW-1:0]     r_last_grant;
  logic              r_out_vld;
  entry_t            r_out;
  logic [NUM_VC-1:0] r_out_tag;

  entry_t            w_head;
  logic              w_empty;
  logic              w_wr;
  logic              w_consumed;
  logic              w_stage_free;
  logic              w_hdr_ok;
  logic              w_drop;
  logic              w_alloc;
  logic              w_fwd;
  logic              w_pop;
  logic              w_any_ready;
  logic [VW-1:0]     w_grant_idx;
  logic [NUM_VC-1:0] w_grant_oh;

  assign Noc_receive_ready = (r_count != 2'd2);
  assign w_wr              = Noc_receive_valid & Noc_receive_ready;
  assign w_empty           = (r_count == 2'd0);
  assign w_head            = r_mem[r_rd_ptr];
  assign w_consumed        = r_out_vld & (|(Noc_sender_ready & r_out_tag));
  assign w_stage_free      = ~r_out_vld | w_consumed;

`ifdef NOC_VC_ALLOC_BRIDGE_ERRCHK_EN
  logic       r_err_orphan;
  logic [7:0] r_err_cnt;

  assign w_hdr_ok   = w_head.hdr;
  assign w_drop     = (r_state == S_IDLE) & ~w_empty & ~w_head.hdr;
  assign err_orphan = r_err_orphan;
  assign err_cnt    = r_err_cnt;
`else
  // Without checking, whatever reaches the head in S_IDLE opens a packet.
  assign w_hdr_ok = 1'b1;
  assign w_drop   = 1'b0;
`endif

  assign w_alloc = (r_state == S_IDLE) & ~w_empty & w_hdr_ok & w_any_ready;
  assign w_fwd   = (r_state == S_PKT) & ~w_empty & w_stage_free;
  assign w_pop   = w_fwd | w_drop;

  always_comb begin : rr_search
    int            j;
    logic [VW-1:0] idx;
    j           = 0;
    idx         = '0;
    w_any_ready = 1'b0;
    w_grant_idx = '0;
    for (int k = 1; k <= NUM_VC; k++) begin
      j = int'(r_last_grant) + k;
      if (j >= NUM_VC) j = j - NUM_VC;
      idx = VW'(j);
      if (!w_any_ready && Noc_sender_VCready[idx]) begin
        w_any_ready = 1'b1;
        w_grant_idx = idx;
      end
    end
  end

  assign w_grant_oh = {{(NUM_VC-1){1'b0}}, 1'b1} << w_grant_idx;

  assign Noc_sender_valid     = r_out_vld ? r_out_tag  : '0;
  assign Noc_sender_flit      = r_out_vld ? r_out.flit : '0;
  assign Noc_sender_is_header = r_out_vld & r_out.hdr;
  assign Noc_sender_is_tail   = r_out_vld & r_out.tail;

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      r_mem[0]     <= '0;
      r_mem[1]     <= '0;
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
      r_count      <= 2'd0;
      r_state      <= S_IDLE;
      r_lock_vc    <= '0;
      r_last_grant <= VW'(NUM_VC - 1);
      r_out_vld    <= 1'b0;
      r_out        <= '0;
      r_out_tag    <= '0;
`ifdef NOC_VC_ALLOC_BRIDGE_ERRCHK_EN
      r_err_orphan <= 1'b0;
      r_err_cnt    <= 8'd0;
`endif
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= '{hdr: Noc_receive_is_header, tail: Noc_receive_is_tail,
                             flit: Noc_receive_flit};
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_wr} - {1'b0, w_pop};

      if (w_fwd) begin
        r_out_vld <= 1'b1;
        r_out     <= w_head;
        r_out_tag <= r_lock_vc;
      end else if (w_consumed) begin
        r_out_vld <= 1'b0;
      end

      // Allocation takes its own cycle; the header is popped next cycle from S_PKT.
      case (r_state)
        S_IDLE: begin
          if (w_alloc) begin
            r_lock_vc    <= w_grant_oh;
            r_last_grant <= w_grant_idx;
            r_state      <= S_PKT;
          end
        end
        S_PKT: begin
          if (w_fwd && w_head.tail) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

`ifdef NOC_VC_ALLOC_BRIDGE_ERRCHK_EN
      r_err_orphan <= w_drop;
      if (w_drop && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
`endif
    end
  end

endmodule

// File: tb/tb_noc_vc_alloc_bridge.sv
// Directed bench for noc_vc_alloc_bridge: allocation, round-robin, backpressure, orphan handling and reset.
module tb_noc_vc_alloc_bridge;

  logic        noc_clk = 1'b0;
  logic        noc_rst;
  logic        Noc_receive_valid;
  logic        Noc_receive_ready;
  logic [63:0] Noc_receive_flit;
  logic        Noc_receive_is_header;
  logic        Noc_receive_is_tail;
  logic [3:0]  Noc_sender_valid;
  logic [3:0]  Noc_sender_ready;
  logic [3:0]  Noc_sender_VCready;
  logic [63:0] Noc_sender_flit;
  logic        Noc_sender_is_header;
  logic        Noc_sender_is_tail;
`ifdef NOC_VC_ALLOC_BRIDGE_ERRCHK_EN
  logic        err_orphan;
  logic [7:0]  err_cnt;
`endif

  noc_vc_alloc_bridge #(.DATA_W(64), .NUM_VC(4)) dut (
    .noc_clk              (noc_clk),
    .noc_rst              (noc_rst),
    .Noc_receive_valid    (Noc_receive_valid),
    .Noc_receive_ready    (Noc_receive_ready),
    .Noc_receive_flit     (Noc_receive_flit),
    .Noc_receive_is_header(Noc_receive_is_header),
    .Noc_receive_is_tail  (Noc_receive_is_tail),
    .Noc_sender_valid     (Noc_sender_valid),
    .Noc_sender_ready     (Noc_sender_ready),
    .Noc_sender_VCready   (Noc_sender_VCready),
    .Noc_sender_flit      (Noc_sender_flit),
    .Noc_sender_is_header (Noc_sender_is_header),
    .Noc_sender_is_tail   (Noc_sender_is_tail)
`ifdef NOC_VC_ALLOC_BRIDGE_ERRCHK_EN
    ,
    .err_orphan           (err_orphan),
    .err_cnt              (err_cnt)
`endif
  );

  always #5 noc_clk = ~noc_clk;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          orph_cnt = 0;
  logic [63:0] lg_flit[$];
  logic [3:0]  lg_vc[$];
  logic [1:0]  lg_ht[$];
  int          lg_cyc[$];

  always @(posedge noc_clk) cyc = cyc + 1;

  always @(negedge noc_clk) begin
    if (|(Noc_sender_valid & Noc_sender_ready)) begin
      lg_flit.push_back(Noc_sender_flit);
      lg_vc.push_back(Noc_sender_valid);
      lg_ht.push_back({Noc_sender_is_header, Noc_sender_is_tail});
      lg_cyc.push_back(cyc);
    end
`ifdef NOC_VC_ALLOC_BRIDGE_ERRCHK_EN
    if (err_orphan) orph_cnt = orph_cnt + 1;
`endif
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge noc_clk);
    #1;
  endtask

  task automatic clear_log();
    lg_flit.delete();
    lg_vc.delete();
    lg_ht.delete();
    lg_cyc.delete();
    orph_cnt = 0;
  endtask

  task automatic do_reset();
    noc_rst           = 1'b1;
    Noc_receive_valid = 1'b0;
    tick(2);
    noc_rst = 1'b0;
    clear_log();
  endtask

  // Leaves valid asserted after acceptance so consecutive calls stream back-to-back.
  task automatic send(input logic [63:0] f, input logic h, input logic t, output int acc);
    logic took;
    took                  = 1'b0;
    acc                   = -1;
    Noc_receive_valid     = 1'b1;
    Noc_receive_flit      = f;
    Noc_receive_is_header = h;
    Noc_receive_is_tail   = t;
    for (int i = 0; i < 200 && !took; i++) begin
      @(negedge noc_clk);
      took = Noc_receive_ready;
      @(posedge noc_clk);
      #1;
    end
    if (took) acc = cyc;
    else check_eq("send_timeout", 64'(f), 64'hDEAD);
  endtask

  task automatic idle();
    Noc_receive_valid     = 1'b0;
    Noc_receive_is_header = 1'b0;
    Noc_receive_is_tail   = 1'b0;
  endtask

  task automatic exp_out(input int idx, input logic [63:0] f, input logic [3:0] vc);
    if (idx < lg_flit.size()) begin
      check_eq($sformatf("flit[%0d]", idx), lg_flit[idx], f);
      check_eq($sformatf("vc[%0d]", idx), 64'(lg_vc[idx]), 64'(vc));
    end else begin
      check_eq($sformatf("missing[%0d]", idx), 64'(lg_flit.size()), 64'(idx + 1));
    end
  endtask

  int          a0, a1;
  int          p;
  int          n;

  initial begin
    noc_rst               = 1'b1;
    Noc_receive_valid     = 1'b0;
    Noc_receive_flit      = '0;
    Noc_receive_is_header = 1'b0;
    Noc_receive_is_tail   = 1'b0;
    Noc_sender_ready      = 4'hF;
    Noc_sender_VCready    = 4'hF;
    do_reset();

    // reset state
    check_eq("rst_rx_ready", 64'(Noc_receive_ready), 64'd1);
    check_eq("rst_valid", 64'(Noc_sender_valid), 64'd0);
    check_eq("rst_flit", Noc_sender_flit, 64'd0);
    check_eq("rst_hdr_tail", 64'({Noc_sender_is_header, Noc_sender_is_tail}), 64'd0);

    // 3-flit packet, VC0, header two cycles after acceptance
    send(64'hA1, 1'b1, 1'b0, a0);
    send(64'hA2, 1'b0, 1'b0, a1);
    send(64'hA3, 1'b0, 1'b1, a1);
    idle();
    tick(8);
    check_eq("p1_count", 64'(lg_flit.size()), 64'd3);
    exp_out(0, 64'hA1, 4'b0001);
    exp_out(1, 64'hA2, 4'b0001);
    exp_out(2, 64'hA3, 4'b0001);
    if (lg_flit.size() == 3) begin
      check_eq("p1_latency", 64'(lg_cyc[0] - a0), 64'd2);
      check_eq("p1_back2back", 64'(lg_cyc[2] - lg_cyc[0]), 64'd2);
      check_eq("p1_hdr", 64'(lg_ht[0]), 64'b10);
      check_eq("p1_tail", 64'(lg_ht[2]), 64'b01);
    end

    // two back-to-back 2-flit packets: VC0 then VC1, one bubble
    do_reset();
    send(64'hB1, 1'b1, 1'b0, a0);
    send(64'hB2, 1'b0, 1'b1, a1);
    send(64'hC1, 1'b1, 1'b0, a1);
    send(64'hC2, 1'b0, 1'b1, a1);
    idle();
    tick(8);
    check_eq("p2_count", 64'(lg_flit.size()), 64'd4);
    exp_out(0, 64'hB1, 4'b0001);
    exp_out(1, 64'hB2, 4'b0001);
    exp_out(2, 64'hC1, 4'b0010);
    exp_out(3, 64'hC2, 4'b0010);
    if (lg_flit.size() == 4) check_eq("p2_bubble", 64'(lg_cyc[2] - lg_cyc[1]), 64'd2);

    // VCready restricted to VC2, then round-robin continues at VC3
    do_reset();
    Noc_sender_VCready = 4'b0100;
    send(64'hD1, 1'b1, 1'b0, a0);
    send(64'hD2, 1'b0, 1'b0, a1);
    send(64'hD3, 1'b0, 1'b1, a1);
    idle();
    tick(6);
    Noc_sender_VCready = 4'b1111;
    send(64'hE1, 1'b1, 1'b0, a0);
    send(64'hE2, 1'b0, 1'b1, a1);
    idle();
    tick(8);
    check_eq("p3_count", 64'(lg_flit.size()), 64'd5);
    exp_out(0, 64'hD1, 4'b0100);
    exp_out(2, 64'hD3, 4'b0100);
    exp_out(3, 64'hE1, 4'b1000);
    exp_out(4, 64'hE2, 4'b1000);

    // no VCready for 10 cycles, then VC1 opens
    do_reset();
    Noc_sender_VCready = 4'b0000;
    send(64'h61, 1'b1, 1'b0, a0);
    send(64'h62, 1'b0, 1'b0, a1);
    Noc_receive_flit      = 64'h63;
    Noc_receive_is_header = 1'b0;
    Noc_receive_is_tail   = 1'b1;
    tick(10);
    check_eq("blk_no_out", 64'(lg_flit.size()), 64'd0);
    check_eq("blk_valid", 64'(Noc_sender_valid), 64'd0);
    check_eq("blk_rx_ready", 64'(Noc_receive_ready), 64'd0);
    Noc_sender_VCready = 4'b0010;
    p = cyc;
    send(64'h63, 1'b0, 1'b1, a1);
    idle();
    tick(8);
    check_eq("blk_count", 64'(lg_flit.size()), 64'd3);
    exp_out(0, 64'h61, 4'b0010);
    exp_out(2, 64'h63, 4'b0010);
    if (lg_flit.size() > 0) check_eq("blk_latency", 64'(lg_cyc[0] - p), 64'd2);

    // downstream stall on VC0 mid-packet
    do_reset();
    Noc_sender_VCready = 4'hF;
    fork
      begin
        send(64'hC1, 1'b1, 1'b0, a0);
        send(64'hC2, 1'b0, 1'b0, a1);
        send(64'hC3, 1'b0, 1'b0, a1);
        send(64'hC4, 1'b0, 1'b0, a1);
        send(64'hC5, 1'b0, 1'b1, a1);
        idle();
      end
      begin
        n = 0;
        while (lg_flit.size() < 2 && n < 100) begin
          @(posedge noc_clk);
          n++;
        end
        #1;
        Noc_sender_ready = 4'b1110;
        for (int i = 0; i < 5; i++) begin
          check_eq("stall_flit", Noc_sender_flit, 64'hC3);
          check_eq("stall_valid", 64'(Noc_sender_valid), 64'b0001);
          tick(1);
        end
        check_eq("stall_rx_ready", 64'(Noc_receive_ready), 64'd0);
        Noc_sender_ready = 4'hF;
      end
    join
    tick(8);
    check_eq("stall_count", 64'(lg_flit.size()), 64'd5);
    for (int i = 0; i < 5; i++) exp_out(i, 64'hC1 + 64'(i), 4'b0001);

    // body flit arriving with no open packet
    do_reset();
    send(64'h55, 1'b0, 1'b0, a0);
    idle();
    tick(6);
`ifdef NOC_VC_ALLOC_BRIDGE_ERRCHK_EN
    check_eq("orph_dropped", 64'(lg_flit.size()), 64'd0);
    check_eq("orph_pulses", 64'(orph_cnt), 64'd1);
    check_eq("orph_cnt", 64'(err_cnt), 64'd1);
`else
    check_eq("orph_count", 64'(lg_flit.size()), 64'd1);
    exp_out(0, 64'h55, 4'b0001);
`endif

    // reset in the middle of a 4-flit packet
    do_reset();
    send(64'h71, 1'b1, 1'b0, a0);
    send(64'h72, 1'b0, 1'b0, a1);
    idle();
    n = 0;
    while (Noc_sender_valid == 4'b0000 && n < 20) begin
      tick(1);
      n++;
    end
    check_eq("mid_valid_before", 64'(Noc_sender_valid), 64'b0001);
    noc_rst = 1'b1;
    tick(1);
    noc_rst = 1'b0;
    check_eq("mid_valid_after", 64'(Noc_sender_valid), 64'd0);
    check_eq("mid_rx_ready", 64'(Noc_receive_ready), 64'd1);
    clear_log();
    send(64'h81, 1'b1, 1'b0, a0);
    send(64'h82, 1'b0, 1'b1, a1);
    idle();
    tick(8);
    check_eq("mid_count", 64'(lg_flit.size()), 64'd2);
    exp_out(0, 64'h81, 4'b0001);
    exp_out(1, 64'h82, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
